// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg: shared definitions for the stepping CPU.
//   - opcode constants decoded by cpu_alu
//   - state_e: the four-state instruction sequencer encoding
//   - instr_t / ROM_TABLE / rom_read: 16-entry instruction ROM, {opcode, A, B}
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [7:0] OP_ADD = 8'h00;
   localparam logic [7:0] OP_SUB = 8'h01;
   localparam logic [7:0] OP_AND = 8'h02;
   localparam logic [7:0] OP_OR  = 8'h03;
   localparam logic [7:0] OP_XOR = 8'h04;
   localparam logic [7:0] OP_NOT = 8'h05;
   localparam logic [7:0] OP_SHL = 8'h06;
   localparam logic [7:0] OP_SHR = 8'h07;
   localparam logic [7:0] OP_NOP = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] a;
      logic [7:0] b;
   } instr_t;

   localparam logic [23:0] ROM_TABLE [16] = '{
      {OP_ADD, 8'h05, 8'h03},
      {OP_ADD, 8'hFF, 8'h01},
      {OP_SUB, 8'h03, 8'h05},
      {OP_AND, 8'hF0, 8'h3C},
      {OP_OR,  8'h0F, 8'h30},
      {OP_XOR, 8'hAA, 8'hFF},
      {OP_NOT, 8'h55, 8'h00},
      {OP_SHL, 8'h81, 8'h00},
      {OP_SHR, 8'h80, 8'h00},
      {OP_NOP, 8'h00, 8'h00},
      {OP_NOP, 8'h00, 8'h00},
      {OP_NOP, 8'h00, 8'h00},
      {OP_NOP, 8'h00, 8'h00},
      {OP_NOP, 8'h00, 8'h00},
      {OP_NOP, 8'h00, 8'h00},
      {OP_NOP, 8'h00, 8'h00}
   };

   function automatic instr_t rom_read(input logic [3:0] idx);
      return instr_t'(ROM_TABLE[idx]);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// -----------------------------------------------------------------------------
// cpu_alu: purely combinational 8-bit ALU, all arithmetic wraps modulo 256.
// Ports:
//   opcode  in  8  operation select (cpu_pkg OP_* constants)
//   a, b    in  8  signed operands
//   result  out 8  signed result, 0 for undefined opcodes
//   carry   out 1  ADD bit 8, SHL A[7], SHR A[0]; else 0
//   borrow  out 1  SUB unsigned A<B; else 0
// -----------------------------------------------------------------------------
module cpu_alu
   import cpu_pkg::*;
(
   input  logic        [7:0] opcode,
   input  logic signed [7:0] a,
   input  logic signed [7:0] b,
   output logic signed [7:0] result,
   output logic              carry,
   output logic              borrow
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      result = '0;
      carry  = 1'b0;
      borrow = 1'b0;
      case (opcode)
         OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            borrow = $unsigned(a) < $unsigned(b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin
            result = {a[6:0], 1'b0};
            carry  = a[7];
         end
         OP_SHR: begin
            result = a >>> 1;  // a is signed, so the sign bit is replicated
            carry  = a[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu.sv
// -----------------------------------------------------------------------------
// cpu: single-step CPU. Each rising edge of next_out (seen while idle) runs
// one ROM instruction through IDLE -> FETCH -> EXEC -> DONE -> IDLE.
// Ports:
//   clk             in   1  clock, rising edge
//   rst             in   1  synchronous active-high reset
//   next_out        in   1  step request (rising edge)
//   opcode          out  8  opcode of current/last instruction
//   operand_A_out   out  8  signed operand A
//   operand_B_out   out  8  signed operand B
//   result_out_cpu  out  8  signed ALU result
//   carry_out_cpu   out  1  ALU carry flag
//   borrow_out_cpu  out  1  ALU borrow flag
//   result_ready    out  1  one-cycle pulse while in DONE
//   data_out        out  1  result outputs hold a completed result
//   pc_out          out  8  index of the next instruction
// -----------------------------------------------------------------------------
module cpu
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              next_out,
   output logic        [7:0] opcode,
   output logic signed [7:0] operand_A_out,
   output logic signed [7:0] operand_B_out,
   output logic signed [7:0] result_out_cpu,
   output logic              carry_out_cpu,
   output logic              borrow_out_cpu,
   output logic              result_ready,
   output logic              data_out,
   output logic        [7:0] pc_out
);

   state_e             state_q, state_d;
   logic               next_q;
   logic        [7:0]  pc_q;
   logic        [7:0]  opcode_q;
   logic signed [7:0]  a_q, b_q;
   logic signed [7:0]  result_q;
   logic               carry_q, borrow_q;
   logic               data_q;
   logic               request;
   instr_t             instr;
   logic signed [7:0]  alu_result;
   logic               alu_carry, alu_borrow;

   // Rising edge of next_out; only acted on in IDLE by the FSM below.
   assign request = next_out & ~next_q;
   assign instr   = rom_read(pc_q[3:0]);

   cpu_alu u_alu (
      .opcode (opcode_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .carry  (alu_carry),
      .borrow (alu_borrow)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q  <= S_IDLE;
         next_q   <= 1'b0;
         pc_q     <= '0;
         opcode_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         data_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         next_q  <= next_out;
         case (state_q)
            S_FETCH: begin
               opcode_q <= instr.opcode;
               a_q      <= instr.a;
               b_q      <= instr.b;
               data_q   <= 1'b0;
            end
            S_EXEC: begin
               result_q <= alu_result;
               carry_q  <= alu_carry;
               borrow_q <= alu_borrow;
               // Set here so data_out is already high during DONE.
               data_q   <= 1'b1;
            end
            S_DONE:  pc_q <= pc_q + 8'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      result_ready = 1'b0;
      case (state_q)
         S_IDLE:  if (request) state_d = S_FETCH;
         S_FETCH: state_d = S_EXEC;
         S_EXEC:  state_d = S_DONE;
         S_DONE: begin
            result_ready = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign opcode         = opcode_q;
   assign operand_A_out  = a_q;
   assign operand_B_out  = b_q;
   assign result_out_cpu = result_q;
   assign carry_out_cpu  = carry_q;
   assign borrow_out_cpu = borrow_q;
   assign data_out       = data_q;
   assign pc_out         = pc_q;

endmodule

// File: tb/tb_cpu.sv
// -----------------------------------------------------------------------------
// tb_cpu: directed self-checking bench for cpu. Inputs change and outputs are
// sampled on the falling edge; result_ready pulses are counted on the rising
// edge by a separate monitor.
// -----------------------------------------------------------------------------
module tb_cpu;

   logic              clk = 1'b0;
   logic              rst;
   logic              next_out;
   logic        [7:0] opcode;
   logic signed [7:0] operand_A_out;
   logic signed [7:0] operand_B_out;
   logic signed [7:0] result_out_cpu;
   logic              carry_out_cpu;
   logic              borrow_out_cpu;
   logic              result_ready;
   logic              data_out;
   logic        [7:0] pc_out;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   int cap_n  = 0;
   logic [7:0] cap_res [32];
   logic       cap_c   [32];
   logic       cap_b   [32];

   cpu dut (
      .clk            (clk),
      .rst            (rst),
      .next_out       (next_out),
      .opcode         (opcode),
      .operand_A_out  (operand_A_out),
      .operand_B_out  (operand_B_out),
      .result_out_cpu (result_out_cpu),
      .carry_out_cpu  (carry_out_cpu),
      .borrow_out_cpu (borrow_out_cpu),
      .result_ready   (result_ready),
      .data_out       (data_out),
      .pc_out         (pc_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (result_ready) begin
         pulses = pulses + 1;
         if (cap_n < 32) begin
            cap_res[cap_n] = result_out_cpu;
            cap_c[cap_n]   = carry_out_cpu;
            cap_b[cap_n]   = borrow_out_cpu;
            cap_n = cap_n + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Rising edge on next_out, then wait (bounded) for the DONE pulse.
   task automatic step(input string tag);
      int n;
      next_out = 1'b0;
      tick();
      next_out = 1'b1;
      n = 0;
      tick();
      while (!result_ready && n < 10) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, {7'd0, result_ready}, 8'h01);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_opc"},   opcode,                      8'h00);
      check({tag, "_a"},     operand_A_out,               8'h00);
      check({tag, "_b"},     operand_B_out,               8'h00);
      check({tag, "_res"},   result_out_cpu,              8'h00);
      check({tag, "_flags"}, {6'd0, carry_out_cpu, borrow_out_cpu}, 8'h00);
      check({tag, "_rdy"},   {7'd0, result_ready},        8'h00);
      check({tag, "_data"},  {7'd0, data_out},            8'h00);
      check({tag, "_pc"},    pc_out,                      8'h00);
   endtask

   initial begin
      logic [7:0] exp_res [9];
      logic       exp_c   [9];
      logic       exp_b   [9];
      int p0, c0;
      exp_res = '{8'h08, 8'h00, 8'hFE, 8'h30, 8'h3F, 8'h55, 8'hAA, 8'h02, 8'hC0};
      exp_c   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_b   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset with next_out already high.
      rst = 1'b1;
      next_out = 1'b1;
      repeat (3) tick();
      check_zero("reset");

      // First post-reset cycle takes the held-high next_out as a request.
      rst = 1'b0;
      tick();
      check("lat_t1_rdy", {7'd0, result_ready}, 8'h00);
      tick();
      check("lat_t2_rdy", {7'd0, result_ready}, 8'h00);
      tick();
      check("lat_t3_rdy", {7'd0, result_ready}, 8'h01);
      check("e0_res",  result_out_cpu,          8'h08);
      check("e0_c",    {7'd0, carry_out_cpu},   8'h00);
      check("e0_b",    {7'd0, borrow_out_cpu},  8'h00);
      check("e0_data", {7'd0, data_out},        8'h01);
      check("e0_opA",  operand_A_out,           8'h05);
      check("e0_opB",  operand_B_out,           8'h03);
      tick();
      check("e0_rdy_off", {7'd0, result_ready}, 8'h00);
      check("e0_pc",   pc_out,                  8'h01);

      step("e1");
      check("e1_res", result_out_cpu,         8'h00);
      check("e1_c",   {7'd0, carry_out_cpu},  8'h01);
      tick();
      check("e1_pc",  pc_out,                 8'h02);

      step("e2");
      check("e2_res", result_out_cpu,         8'hFE);
      check("e2_b",   {7'd0, borrow_out_cpu}, 8'h01);
      tick();
      check("e2_pc",  pc_out,                 8'h03);

      // Reset during EXEC aborts the instruction.
      next_out = 1'b0;
      tick();
      next_out = 1'b1;
      tick();          // FETCH
      tick();          // EXEC
      rst = 1'b1;
      p0 = pulses;
      tick();
      check_zero("rst_exec");
      next_out = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      repeat (5) tick();
      check("rst_exec_nopulse", 8'(pulses - p0), 8'h00);
      check("rst_exec_pc",      pc_out,          8'h00);

      // Toggle next_out every 10 cycles for 9 rising edges.
      p0 = pulses;
      c0 = cap_n;
      for (int i = 0; i < 9; i++) begin
         next_out = 1'b1;
         repeat (10) tick();
         next_out = 1'b0;
         repeat (10) tick();
      end
      check("tog_pulses", 8'(pulses - p0), 8'd9);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("tog%0d_res", i), cap_res[c0+i], exp_res[i]);
         check($sformatf("tog%0d_c", i),   {7'd0, cap_c[c0+i]}, {7'd0, exp_c[i]});
         check($sformatf("tog%0d_b", i),   {7'd0, cap_b[c0+i]}, {7'd0, exp_b[i]});
      end
      check("tog_pc", pc_out, 8'd9);

      // Entries 9-15: undefined opcode gives zero result and flags.
      for (int i = 9; i < 16; i++) begin
         step($sformatf("e%0d", i));
         check($sformatf("e%0d_opc", i),   opcode,         8'hFF);
         check($sformatf("e%0d_res", i),   result_out_cpu, 8'h00);
         check($sformatf("e%0d_flags", i), {6'd0, carry_out_cpu, borrow_out_cpu}, 8'h00);
      end
      tick();
      check("wrap_pc16", pc_out, 8'd16);
      step("wrap_e0");
      check("wrap_opc", opcode,         8'h00);
      check("wrap_res", result_out_cpu, 8'h08);
      tick();
      check("wrap_pc17", pc_out, 8'd17);

      // A second rising edge during EXEC is ignored.
      p0 = pulses;
      next_out = 1'b0;
      tick();
      next_out = 1'b1;
      tick();          // FETCH
      next_out = 1'b0;
      tick();          // EXEC
      check("fetch_drop_data", {7'd0, data_out}, 8'h00);
      next_out = 1'b1;
      repeat (12) tick();
      next_out = 1'b0;
      repeat (3) tick();
      check("ign_pulses", 8'(pulses - p0), 8'd1);
      check("ign_pc",     pc_out,          8'd18);
      check("ign_res",    result_out_cpu,  8'h00);
      check("ign_c",      {7'd0, carry_out_cpu}, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port next_out, input, 1 bit: step request; each rising edge requests execution of one instruction.
REQ-004 SHALL have port opcode, output, 8 bits: opcode of the current or last instruction.
REQ-005 SHALL have ports operand_A_out and operand_B_out, outputs, 8 bits each, signed: operands of the current or last instruction.
REQ-006 SHALL have port result_out_cpu, output, 8 bits, signed: ALU result.
REQ-007 SHALL have ports carry_out_cpu and borrow_out_cpu, outputs, 1 bit each: ALU flags.
REQ-008 SHALL have port result_ready, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port data_out, output, 1 bit: high while the result outputs hold a completed, valid result.
REQ-010 SHALL have port pc_out, output, 8 bits: program counter, the index of the next instruction to execute.

Function
REQ-011 SHALL contain a 16-entry instruction ROM; each entry is {opcode[7:0], A[7:0], B[7:0]}, indexed by pc[3:0]; pc is 8 bits and wraps from 255 to 0.
REQ-012 SHALL register next_out into next_q; a request is the condition next_out=1 and next_q=0 while in IDLE; requests in any other state are ignored.
REQ-013 SHALL run the FSM IDLE->FETCH->EXEC->DONE->IDLE, one cycle per state except IDLE; IDLE leaves only on a request.
REQ-014 FETCH SHALL latch opcode, operand_A_out and operand_B_out from ROM[pc[3:0]] and drop data_out to 0.
REQ-015 EXEC SHALL register result_out_cpu, carry_out_cpu and borrow_out_cpu from the latched values.
REQ-016 DONE SHALL assert result_ready for exactly one cycle, set data_out=1 and increment pc.
REQ-017 Latency SHALL be: request sampled in cycle T, then result_ready high in cycle T+3 with the results valid at that cycle.
REQ-018 Opcodes; all arithmetic is 8-bit and wraps modulo 256:
- 0x00 ADD: result A+B; carry = unsigned bit 8.
- 0x01 SUB: result A-B; borrow = (A<B unsigned).
- 0x02 AND.
- 0x03 OR.
- 0x04 XOR.
- 0x05 NOT A.
- 0x06 SHL A by 1; carry = A[7].
- 0x07 arithmetic SHR A by 1; carry = A[0].
REQ-019 Flags not defined for an opcode SHALL be 0; an undefined opcode SHALL give result 0 and both flags 0.
REQ-020 ROM contents SHALL be:
- 0: ADD 0x05,0x03.
- 1: ADD 0xFF,0x01.
- 2: SUB 0x03,0x05.
- 3: AND 0xF0,0x3C.
- 4: OR 0x0F,0x30.
- 5: XOR 0xAA,0xFF.
- 6: NOT 0x55.
- 7: SHL 0x81.
- 8: SHR 0x80.
- 9-15: opcode 0xFF with operands 0x00.

Reset
REQ-021 While rst=1, the block SHALL be in IDLE, all outputs SHALL be 0, pc SHALL be 0 and next_q SHALL be 0.
REQ-022 Because next_q resets to 0, a next_out that is high in the first cycle after reset SHALL be taken as a request.
REQ-023 Reset in any state SHALL abort the instruction in progress; pc SHALL not advance and result_ready SHALL not pulse.

Structure
REQ-024 The opcode constants, the state enum and the ROM table SHALL be in a shared package cpu_pkg.
REQ-025 The combinational ALU SHALL be the sub-module cpu_alu (inputs opcode, a, b; outputs result, carry, borrow).

Verification
REQ-026 Reset, then next_out held at 1 -> entry 0 executes: result 0x08, carry 0, borrow 0, pc_out 1, result_ready pulse 3 cycles after the first post-reset cycle.
REQ-027 Second next_out rising edge -> result 0x00, carry 1, pc_out 2; third edge -> result 0xFE, borrow 1, pc_out 3.
REQ-028 Toggle next_out every 10 cycles for 9 edges -> results in order 08,00,FE,30,3F,55,AA,02(carry 1),C0(carry 0); exactly one result_ready pulse per edge.
REQ-029 Raise next_out again during FETCH or EXEC -> ignored: a single result_ready pulse and pc advances by 1.
REQ-030 Assert rst during EXEC -> all outputs 0, pc_out 0, no result_ready pulse.
REQ-031 After 16 instructions -> pc_out 16 and execution restarts at ROM entry 0; entries 9-15 give result 0 with both flags 0.
